sp_ram_pipe: RTL and testbench
==============================

// Module: sp_ram_pipe
// PURPOSE
//   Parametrised single-port synchronous RAM; next generation of the s_ram block.
//   Adds byte write enables, selectable read latency (1 or 2), a read-valid strobe,
//   and a hardware init sweep that fills every word with INIT_VAL after reset or on clr.
//   Sits behind a single requester as local scratch storage; ready gates all requests.
// PARAMETERS
//   DATA_W    8   word width in bits; must be a multiple of 8
//   ADDR_W    4   address width; DEPTH = 2**ADDR_W words
//   READ_LAT  1   read latency in cycles (accept edge to rd_valid); legal values 1, 2
//   INIT_VAL  0   DATA_W-bit value written to every word by the init sweep
// PORTS
//   clk        in   1          clock, rising edge
//   rst        in   1          asynchronous reset, active-high
//   en         in   1          request valid; accepted when en && ready
//   we         in   1          1 = write, 0 = read (sampled with en)
//   be         in   DATA_W/8   byte write enables, be[i] -> data_in[8i+7:8i]; ignored on reads
//   addr       in   ADDR_W     word address
//   data_in    in   DATA_W     write data
//   clr        in   1          1-cycle pulse: rerun the init sweep
//   ready      out  1          ready = (state==RUN) && !clr
//   data_out   out  DATA_W     read data; holds its last value between reads
//   rd_valid   out  1          1-cycle pulse: data_out carries a new read result
//   init_done  out  1          1 when state==RUN
// BEHAVIOUR
//   Reset (async assert): state=INIT, sweep counter=0, read pipeline flushed,
//     data_out=0, rd_valid=0, ready=0, init_done=0. Array contents are not reset.
//   FSM INIT: after rst deasserts, each cycle writes INIT_VAL to mem[cnt], cnt++.
//     The cycle that writes DEPTH-1 moves to RUN, so ready rises exactly DEPTH cycles
//     after the first clk edge with rst low. en is ignored in INIT; clr is ignored in INIT.
//   FSM RUN: clr=1 -> INIT with cnt=0. The request in that cycle is dropped (ready=0).
//   Write: accepted at edge T; bytes with be[i]=1 are updated at T; no rd_valid.
//     A read of the same address accepted at T+1 returns the new data.
//   Read: accepted at edge T; data_out and rd_valid are registered at edge T+READ_LAT-1.
//     READ_LAT=1: visible in the cycle after T. READ_LAT=2: one extra output register.
//   Throughput: one request per cycle; back-to-back reads give continuous rd_valid.
//   Reads already in the pipeline when clr is taken still complete with their rd_valid
//     and return pre-clear data.
//   Address wraps naturally (ADDR_W bits; no out-of-range case).
//   rst asserted mid-operation: in-flight reads are discarded (no rd_valid).
//     The sweep restarts from 0.
// TESTING
//   T1 init: rst high 20ns then low, DEPTH=16 -> ready=0 for 16 clks, then 1;
//      read each addr 0..15 -> 0x00 with rd_valid.
//   T2 rd/wr: write 0xA5 to addr 3 (be=1), read addr 3 -> data_out=0xA5 and
//      rd_valid after READ_LAT clks; run for READ_LAT=1 and 2.
//   T3 byte enable (DATA_W=32): write 0x11223344 be=4'hF to addr 5, then write
//      0xFFFFFFFF be=4'b0010 -> read 0x1122FF44.
//   T4 streaming: write addr k with k*3 for k=0..15, then 16 back-to-back reads ->
//      rd_valid high 16 consecutive clks with data 0,3,..,45 in order.
//   T5 clr: issue 2 reads, pulse clr with en=1 in the same cycle -> both reads return
//      old data, the clr-cycle request is dropped, ready=0 for 16 clks, all words=INIT_VAL.
//   T6 reset mid-op: assert rst one cycle after a read is accepted -> no rd_valid,
//      data_out=0; after rst falls the init sweep reruns.

Source files
------------

// File: rtl/sp_ram_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_pipe
// Description : Single-port synchronous scratch RAM with byte write enables,
//               a 1- or 2-cycle registered read path with a read-valid strobe,
//               and a hardware sweep that fills every word with INIT_VAL after
//               reset or on a clr pulse.
// Ports       : clk, rst       clock (rising edge), async active-high reset
//               en, we, be     request valid, write select, byte enables
//               addr, data_in  word address, write data
//               clr            pulse: rerun the init sweep
//               ready          request accepted when en && ready
//               data_out       read data, held between reads
//               rd_valid       pulse: data_out carries a new read result
//               init_done      high once the sweep has finished
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_pipe #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 4,
    parameter int                 READ_LAT = 1,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  clr,
    output logic                  ready,
    output logic [DATA_W-1:0]     data_out,
    output logic                  rd_valid,
    output logic                  init_done
);

    localparam int                C_DEPTH  = 2**ADDR_W;
    localparam int                C_NBYTES = DATA_W/8;
    localparam logic [ADDR_W-1:0] C_LAST   = ADDR_W'(C_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_cnt;
    logic [ADDR_W-1:0]  w_cnt_nxt;

    logic [DATA_W-1:0]  r_mem [C_DEPTH];

    logic               w_accept;
    logic               w_wr;
    logic               w_rd;
    logic [DATA_W-1:0]  w_rd_word;

    logic [DATA_W-1:0]  r_data_out;
    logic               r_rd_valid;

    // ------------------------------------------------------------------------
    // Sweep / run state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                // clr is deliberately not looked at here: a sweep in progress
                // already produces the state a clear would.
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == C_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clr) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // clr masks ready in its own cycle so the coincident request is dropped
    assign ready     = (r_state == ST_RUN) && !clr;
    assign init_done = (r_state == ST_RUN);

    assign w_accept  = en && ready;
    assign w_wr      = w_accept && we;
    assign w_rd      = w_accept && !we;

    // ------------------------------------------------------------------------
    // Storage array (never reset; the sweep provides the defined contents)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= INIT_VAL;
        end else if (w_wr) begin
            for (int i = 0; i < C_NBYTES; i++) begin
                if (be[i]) begin
                    r_mem[addr][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    assign w_rd_word = r_mem[addr];

    // ------------------------------------------------------------------------
    // Read pipeline. Any READ_LAT other than 2 builds the 1-cycle path.
    // ------------------------------------------------------------------------
    generate
        if (READ_LAT == 2) begin : g_lat2
            logic               r_s1_valid;
            logic [DATA_W-1:0]  r_s1_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s1_valid <= 1'b0;
                    r_s1_data  <= '0;
                    r_rd_valid <= 1'b0;
                    r_data_out <= '0;
                end else begin
                    r_s1_valid <= w_rd;
                    if (w_rd) begin
                        r_s1_data <= w_rd_word;
                    end
                    r_rd_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_data_out <= r_s1_data;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_valid <= 1'b0;
                    r_data_out <= '0;
                end else begin
                    r_rd_valid <= w_rd;
                    if (w_rd) begin
                        r_data_out <= w_rd_word;
                    end
                end
            end
        end
    endgenerate

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_ram_pipe
// Description : Self-checking bench for sp_ram_pipe. Two instances (read
//               latency 1 and 2, 32-bit words, 16 words) share one stimulus
//               stream; each has its own expected-read queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  addr;
    logic [31:0] data_in;
    logic        clr;

    logic        ready1, rv1, done1;
    logic [31:0] dout1;
    logic        ready2, rv2, done2;
    logic [31:0] dout2;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] model [16];
    int          nclk  = 0;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    sp_ram_pipe #(.DATA_W(32), .ADDR_W(4), .READ_LAT(1), .INIT_VAL(32'h0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr),
        .data_in(data_in), .clr(clr), .ready(ready1), .data_out(dout1),
        .rd_valid(rv1), .init_done(done1)
    );

    sp_ram_pipe #(.DATA_W(32), .ADDR_W(4), .READ_LAT(2), .INIT_VAL(32'h0)) dut2 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr),
        .data_in(data_in), .clr(clr), .ready(ready2), .data_out(dout2),
        .rd_valid(rv2), .init_done(done2)
    );

    // Advance to the next falling edge and retire any read results.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        nclk++;
        if (rv1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL lat1_unexpected_rd_valid: got rd_valid=1 data=%h at cycle %0d, required no read pending", dout1, nclk);
            end else begin
                e = q1.pop_front();
                if (dout1 !== e.data || nclk != e.due) begin
                    bad++;
                    $display("FAIL lat1_read: got data=%h at cycle %0d, required %h at cycle %0d", dout1, nclk, e.data, e.due);
                end
            end
        end
        if (q1.size() != 0 && q1[0].due < nclk) begin
            total++; bad++;
            $display("FAIL lat1_missing_rd_valid: got rd_valid=0 by cycle %0d, required data %h at cycle %0d", nclk, q1[0].data, q1[0].due);
            void'(q1.pop_front());
        end
        if (rv2) begin
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL lat2_unexpected_rd_valid: got rd_valid=1 data=%h at cycle %0d, required no read pending", dout2, nclk);
            end else begin
                e = q2.pop_front();
                if (dout2 !== e.data || nclk != e.due) begin
                    bad++;
                    $display("FAIL lat2_read: got data=%h at cycle %0d, required %h at cycle %0d", dout2, nclk, e.data, e.due);
                end
            end
        end
        if (q2.size() != 0 && q2[0].due < nclk) begin
            total++; bad++;
            $display("FAIL lat2_missing_rd_valid: got rd_valid=0 by cycle %0d, required data %h at cycle %0d", nclk, q2[0].data, q2[0].due);
            void'(q2.pop_front());
        end
    endtask

    // One accepted request; reads queue the model word with each latency.
    task automatic req(input logic w, input logic [3:0] b, input logic [3:0] a, input logic [31:0] d);
        tick();
        en = 1'b1; we = w; be = b; addr = a; data_in = d; clr = 1'b0;
        if (w) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
            end
        end else begin
            q1.push_back('{data: model[a], due: nclk + 1});
            q2.push_back('{data: model[a], due: nclk + 2});
        end
    endtask

    task automatic idle();
        tick();
        en = 1'b0; we = 1'b0; clr = 1'b0;
    endtask

    task automatic drain();
        repeat (4) idle();
        total++;
        if (q1.size() != 0 || q2.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d reads outstanding, required 0/0", q1.size(), q2.size());
        end
    endtask

    // 16 cycles of sweep: requests and a clr pulse are offered and must be
    // ignored; ready must rise on exactly the 16th edge.
    task automatic sweep_check(input string tag);
        for (int k = 1; k <= 16; k++) begin
            tick();
            total++;
            if (ready1 !== (k == 16) || ready2 !== (k == 16) ||
                done1 !== (k == 16) || done2 !== (k == 16)) begin
                bad++;
                $display("FAIL %s_ready_k%0d: got ready=%b/%b init_done=%b/%b, required %b", tag, k,
                         ready1, ready2, done1, done2, (k == 16));
            end
            en      = (k < 16);
            we      = k[0];
            be      = 4'hF;
            addr    = k[3:0];
            data_in = 32'hFFFF_FFFF;
            clr     = (k == 5);
        end
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; we = 1'b0; be = 4'h0; addr = 4'h0; data_in = 32'h0; clr = 1'b0;
        tick();
        total++;
        if (ready1 !== 1'b0 || ready2 !== 1'b0 || done1 !== 1'b0 || done2 !== 1'b0 ||
            rv1 !== 1'b0 || rv2 !== 1'b0 || dout1 !== 32'h0 || dout2 !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: got ready=%b/%b done=%b/%b rv=%b/%b dout=%h/%h, required all 0",
                     ready1, ready2, done1, done2, rv1, rv2, dout1, dout2);
        end
        tick();
        rst = 1'b0;
        sweep_check("init");
        for (int a = 0; a < 16; a++) req(1'b0, 4'h0, a[3:0], 32'h0);
        drain();
    endtask

    task automatic test_rdwr();
        req(1'b1, 4'h1, 4'd3, 32'h0000_00A5);
        req(1'b0, 4'h0, 4'd3, 32'h0);
        drain();
        total++;
        if (dout1 !== 32'h0000_00A5 || dout2 !== 32'h0000_00A5) begin
            bad++;
            $display("FAIL rdwr_hold: got %h/%h, required 000000a5", dout1, dout2);
        end
    endtask

    task automatic test_byte_en();
        req(1'b1, 4'hF, 4'd5, 32'h1122_3344);
        req(1'b1, 4'b0010, 4'd5, 32'hFFFF_FFFF);
        req(1'b0, 4'h0, 4'd5, 32'h0);
        drain();
        total++;
        if (dout1 !== 32'h1122_FF44 || dout2 !== 32'h1122_FF44) begin
            bad++;
            $display("FAIL byte_en: got %h/%h, required 1122ff44", dout1, dout2);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) req(1'b1, 4'hF, k[3:0], k * 3);
        for (int k = 0; k < 16; k++) req(1'b0, 4'h0, k[3:0], 32'h0);
        drain();
    endtask

    task automatic test_clr();
        req(1'b0, 4'h0, 4'd1, 32'h0);
        req(1'b0, 4'h0, 4'd2, 32'h0);
        tick();
        en = 1'b1; we = 1'b0; addr = 4'd4; clr = 1'b1;
        #1;
        total++;
        if (ready1 !== 1'b0 || ready2 !== 1'b0) begin
            bad++;
            $display("FAIL clr_ready_mask: got ready=%b/%b with clr=1, required 0/0", ready1, ready2);
        end
        tick();
        total++;
        if (ready1 !== 1'b0 || ready2 !== 1'b0) begin
            bad++;
            $display("FAIL clr_enter_init: got ready=%b/%b, required 0/0", ready1, ready2);
        end
        en = 1'b0; clr = 1'b0;
        sweep_check("clr");
        for (int a = 0; a < 16; a++) req(1'b0, 4'h0, a[3:0], 32'h0);
        drain();
    endtask

    task automatic test_rst_mid();
        req(1'b1, 4'hF, 4'd7, 32'hDEAD_BEEF);
        req(1'b0, 4'h0, 4'd7, 32'h0);
        drain();
        // This read is accepted and then killed by reset; nothing is queued.
        tick();
        en = 1'b1; we = 1'b0; addr = 4'd7;
        @(posedge clk);
        #1;
        rst = 1'b1; en = 1'b0;
        tick();
        total++;
        if (rv1 !== 1'b0 || rv2 !== 1'b0 || dout1 !== 32'h0 || dout2 !== 32'h0 ||
            ready1 !== 1'b0 || ready2 !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_flush: got rv=%b/%b dout=%h/%h ready=%b/%b, required 0",
                     rv1, rv2, dout1, dout2, ready1, ready2);
        end
        tick();
        rst = 1'b0;
        sweep_check("rst_mid");
        req(1'b0, 4'h0, 4'd7, 32'h0);
        drain();
    endtask

    initial begin
        test_reset();
        test_rdwr();
        test_byte_en();
        test_back_to_back();
        test_clr();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
